am9150_bank_seq: RTL and testbench

- Access sequencer directly upstream of one AM9150_20 1Kx4 static RAM.
- Converts a single-word request/response handshake from the memory-bus logic into correctly timed A/D/S_n/W_n/G_n strobes, and captures read data from the RAM's Q bus.
- After reset it sweeps the whole RAM to a known value before accepting requests.

---
 rtl/am9150_seq_pkg.sv | 54 +++++
 rtl/am9150_bank_seq_if.sv | 28 ++
 rtl/am9150_phase_timer.sv | 37 +++
 rtl/am9150_bank_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_am9150_bank_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/am9150_seq_pkg.sv
// am9150_seq_pkg
//   Shared types and constants for the AM9150_20 bank sequencer.
//   Contents: bus widths, RAM depth, phase-counter width, FSM state enum
//   (extended with verify-read states when AM9150_SEQ_VERIFY_EN is defined)
//   and a helper that turns a phase length into a counter load value.
package am9150_seq_pkg;

  localparam int AW        = 10;
  localparam int DW        = 4;
  localparam int RAM_WORDS = 1024;
  localparam int PHASE_W   = 4;

  localparam logic [AW-1:0]      LAST_ADDR = AW'(RAM_WORDS - 1);
  localparam logic [AW-1:0]      ADDR_INC  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0] PHASE_ONE = {{(PHASE_W-1){1'b0}}, 1'b1};

`ifdef AM9150_SEQ_VERIFY_EN
  typedef enum logic [3:0] {
    ST_INIT_SETUP  = 4'd0,
    ST_INIT_STROBE = 4'd1,
    ST_INIT_HOLD   = 4'd2,
    ST_IDLE        = 4'd3,
    ST_SETUP       = 4'd4,
    ST_STROBE      = 4'd5,
    ST_HOLD        = 4'd6,
    ST_RESP        = 4'd7,
    ST_V_SETUP     = 4'd8,
    ST_V_STROBE    = 4'd9,
    ST_V_HOLD      = 4'd10
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_INIT_SETUP  = 3'd0,
    ST_INIT_STROBE = 3'd1,
    ST_INIT_HOLD   = 3'd2,
    ST_IDLE        = 3'd3,
    ST_SETUP       = 3'd4,
    ST_STROBE      = 3'd5,
    ST_HOLD        = 3'd6,
    ST_RESP        = 3'd7
  } state_t;
`endif

  // A phase of length N runs while the counter steps N-1 .. 0.
  // Zero-length phases are never entered, so their load value is unused.
  function automatic logic [PHASE_W-1:0] phase_load(input int unsigned len);
    if (len == 32'd0) begin
      return {PHASE_W{1'b0}};
    end else begin
      return PHASE_W'(len - 32'd1);
    end
  endfunction

endpackage

// File: rtl/am9150_bank_seq_if.sv
// am9150_bank_seq_if
//   Single-word request/response handshake between the memory-bus logic
//   (master) and the bank sequencer (slave).
//   req_valid/req_we/req_addr/req_wdata : request from master
//   req_ready                           : sequencer can accept this cycle
//   rsp_valid/rsp_rdata                 : completion pulse and read data
interface am9150_bank_seq_if;
  import am9150_seq_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/am9150_phase_timer.sv
// am9150_phase_timer
//   Down-counter timing one strobe phase. Loaded on every state change,
//   then counts to zero and holds there.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val this cycle
//   load_val  : phase length minus one
//   done      : counter is zero (last cycle of the current phase)
module am9150_phase_timer
  import am9150_seq_pkg::*;
#(
  parameter logic [PHASE_W-1:0] RST_VAL = {PHASE_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               done
);

  logic [PHASE_W-1:0] count_r;

  // Phase down-counter: load on state entry, otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= RST_VAL;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {PHASE_W{1'b0}}) begin
      count_r <= count_r - PHASE_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {PHASE_W{1'b0}});

endmodule

// File: rtl/am9150_bank_seq.sv
// am9150_bank_seq
//   Access sequencer for one AM9150_20 1Kx4 SRAM. After reset it writes
//   INIT_VALUE to all 1024 words, then serves single-word requests with
//   SETUP_CYC / STROBE_CYC / HOLD_CYC strobe timing. All mem_* outputs are
//   registered and derived from the next state, so each strobe lines up
//   exactly with its FSM state.
//   Optional: AM9150_SEQ_VERIFY_EN adds a read-back after every write and
//   the sticky verify_err output.
// Ports:
//   sysclk, sys_rst     : clock, asynchronous active-high reset
//   req_bus (slave)     : request/response handshake
//   busy                : sweep or access in progress
//   mem_a, mem_d        : RAM address / write data
//   mem_s_n/w_n/g_n/r_n : RAM select, write, output-enable, (unused) R_n
//   mem_q               : RAM read data
//   verify_err          : (verify build only) sticky read-back mismatch
module am9150_bank_seq
  import am9150_seq_pkg::*;
#(
  parameter int unsigned   SETUP_CYC  = 1,
  parameter int unsigned   STROBE_CYC = 2,
  parameter int unsigned   HOLD_CYC   = 1,
  parameter logic [DW-1:0] INIT_VALUE = 4'h0
) (
  input  logic                     sysclk,
  input  logic                     sys_rst,
  am9150_bank_seq_if.slave         req_bus,
  output logic                     busy,
  output logic [AW-1:0]            mem_a,
  output logic [DW-1:0]            mem_d,
  output logic                     mem_s_n,
  output logic                     mem_w_n,
  output logic                     mem_g_n,
  output logic                     mem_r_n,
  input  logic [DW-1:0]            mem_q
`ifdef AM9150_SEQ_VERIFY_EN
  ,
  output logic                     verify_err
`endif
);

  localparam bit HOLD_EN = (HOLD_CYC != 32'd0);

  state_t             state_r, state_nxt_s, after_write_s, after_verify_s;
  logic               sweep_r;
  logic [AW-1:0]      sweep_addr_r;
  logic               we_r;
  logic               accept_s, step_s, g_low_s, phase_done_s;
  logic [PHASE_W-1:0] load_val_s;
  logic [AW-1:0]      mem_a_r;
  logic [DW-1:0]      mem_d_r, rsp_rdata_r;
  logic               mem_s_n_r, mem_w_n_r, mem_g_n_r;
  logic               busy_r, req_ready_r, rsp_valid_r;

  // Extra reset-time count makes the first sweep location's setup span the
  // cycle in which S_n is still at its reset value.
  am9150_phase_timer #(.RST_VAL(PHASE_W'(SETUP_CYC))) u_timer (
    .clk      (sysclk),
    .rst      (sys_rst),
    .load     (state_nxt_s != state_r),
    .load_val (load_val_s),
    .done     (phase_done_s)
  );

  assign accept_s = (state_r == ST_IDLE) && req_bus.req_valid && req_ready_r;
  assign step_s   = (state_nxt_s == ST_INIT_SETUP) && (state_r != ST_INIT_SETUP);

  // Destination once a write (and its read-back, if any) has finished.
  always_comb begin
    after_verify_s = ST_RESP;
    if (sweep_r) begin
      if (sweep_addr_r == LAST_ADDR) begin
        after_verify_s = ST_IDLE;
      end else begin
        after_verify_s = ST_INIT_SETUP;
      end
    end else begin
      after_verify_s = ST_RESP;
    end
  end

`ifdef AM9150_SEQ_VERIFY_EN
  assign after_write_s = ST_V_SETUP;
`else
  assign after_write_s = after_verify_s;
`endif

  // Next-state logic; every phase advances when the timer reaches zero.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT_SETUP:  if (phase_done_s) state_nxt_s = ST_INIT_STROBE; else state_nxt_s = state_r;
      ST_INIT_STROBE: begin
        if (phase_done_s) begin
          if (HOLD_EN) state_nxt_s = ST_INIT_HOLD; else state_nxt_s = after_write_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_INIT_HOLD:   if (phase_done_s) state_nxt_s = after_write_s; else state_nxt_s = state_r;
      ST_IDLE:        if (accept_s) state_nxt_s = ST_SETUP; else state_nxt_s = state_r;
      ST_SETUP:       if (phase_done_s) state_nxt_s = ST_STROBE; else state_nxt_s = state_r;
      ST_STROBE: begin
        if (phase_done_s) begin
          if (HOLD_EN)   state_nxt_s = ST_HOLD;
          else if (we_r) state_nxt_s = after_write_s;
          else           state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_HOLD: begin
        if (phase_done_s) begin
          if (we_r) state_nxt_s = after_write_s; else state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RESP:        state_nxt_s = ST_IDLE;
`ifdef AM9150_SEQ_VERIFY_EN
      ST_V_SETUP:     if (phase_done_s) state_nxt_s = ST_V_STROBE; else state_nxt_s = state_r;
      ST_V_STROBE: begin
        if (phase_done_s) begin
          if (HOLD_EN) state_nxt_s = ST_V_HOLD; else state_nxt_s = after_verify_s;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_V_HOLD:      if (phase_done_s) state_nxt_s = after_verify_s; else state_nxt_s = state_r;
`endif
      default:        state_nxt_s = ST_INIT_SETUP;
    endcase
  end

  // Phase length for the state being entered.
  always_comb begin
    load_val_s = {PHASE_W{1'b0}};
    case (state_nxt_s)
      ST_INIT_SETUP, ST_SETUP:   load_val_s = phase_load(SETUP_CYC);
      ST_INIT_STROBE, ST_STROBE: load_val_s = phase_load(STROBE_CYC);
      ST_INIT_HOLD, ST_HOLD:     load_val_s = phase_load(HOLD_CYC);
`ifdef AM9150_SEQ_VERIFY_EN
      ST_V_SETUP:                load_val_s = phase_load(SETUP_CYC);
      ST_V_STROBE:               load_val_s = phase_load(STROBE_CYC);
      ST_V_HOLD:                 load_val_s = phase_load(HOLD_CYC);
`endif
      default:                   load_val_s = {PHASE_W{1'b0}};
    endcase
  end

  assign g_low_s = ((state_nxt_s == ST_STROBE) && !we_r)
`ifdef AM9150_SEQ_VERIFY_EN
                   || (state_nxt_s == ST_V_STROBE)
`endif
                   ;

  // State register and strobe/handshake outputs registered from next state.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r     <= ST_INIT_SETUP;
      mem_s_n_r   <= 1'b1;
      mem_w_n_r   <= 1'b1;
      mem_g_n_r   <= 1'b1;
      busy_r      <= 1'b1;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mem_s_n_r   <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_RESP);
      mem_w_n_r   <= !((state_nxt_s == ST_INIT_STROBE) || ((state_nxt_s == ST_STROBE) && we_r));
      mem_g_n_r   <= !g_low_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
    end
  end

  // Address/data path: latched at acceptance or advanced at a sweep step only.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      sweep_r      <= 1'b1;
      sweep_addr_r <= {AW{1'b0}};
      mem_a_r      <= {AW{1'b0}};
      mem_d_r      <= {DW{1'b0}};
      we_r         <= 1'b0;
    end else if (accept_s) begin
      mem_a_r <= req_bus.req_addr;
      mem_d_r <= req_bus.req_wdata;
      we_r    <= req_bus.req_we;
    end else if (step_s) begin
      sweep_addr_r <= sweep_addr_r + ADDR_INC;
      mem_a_r      <= sweep_addr_r + ADDR_INC;
    end else if (sweep_r) begin
      mem_d_r <= INIT_VALUE;
      if (state_nxt_s == ST_IDLE) sweep_r <= 1'b0; else sweep_r <= 1'b1;
    end else begin
      mem_a_r <= mem_a_r;
    end
  end

  // Read data capture on the last cycle G_n is low for a request read.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      rsp_rdata_r <= {DW{1'b0}};
    end else if ((state_r == ST_STROBE) && phase_done_s && !we_r) begin
      rsp_rdata_r <= mem_q;
    end else begin
      rsp_rdata_r <= rsp_rdata_r;
    end
  end

`ifdef AM9150_SEQ_VERIFY_EN
  logic verify_err_r;

  // Sticky read-back mismatch flag.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      verify_err_r <= 1'b0;
    end else if ((state_r == ST_V_STROBE) && phase_done_s && (mem_q != mem_d_r)) begin
      verify_err_r <= 1'b1;
    end else begin
      verify_err_r <= verify_err_r;
    end
  end

  assign verify_err = verify_err_r;
`endif

  assign req_bus.req_ready = req_ready_r;
  assign req_bus.rsp_valid = rsp_valid_r;
  assign req_bus.rsp_rdata = rsp_rdata_r;
  assign busy    = busy_r;
  assign mem_a   = mem_a_r;
  assign mem_d   = mem_d_r;
  assign mem_s_n = mem_s_n_r;
  assign mem_w_n = mem_w_n_r;
  assign mem_g_n = mem_g_n_r;
  assign mem_r_n = 1'b1;

endmodule

// File: tb/tb_am9150_bank_seq.sv
// tb_am9150_bank_seq
//   Bench for am9150_bank_seq: dut1 uses default timing against a 1Kx4
//   RAM model, dut2 uses SETUP=3/STROBE=1/HOLD=0. Table of single accesses
//   plus hand-written sweep, back-to-back and reset-abort sequences.
//   Honours AM9150_SEQ_VERIFY_EN.
module tb_am9150_bank_seq;
  import am9150_seq_pkg::*;

`ifdef AM9150_SEQ_VERIFY_EN
  localparam int WL1 = 9, WS1 = 8, WG1 = 2, WL2 = 9, WS2 = 8, WG2 = 1;
`else
  localparam int WL1 = 5, WS1 = 4, WG1 = 0, WL2 = 5, WS2 = 4, WG2 = 0;
`endif

  logic sysclk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sysclk = ~sysclk;

  am9150_bank_seq_if bus1();
  am9150_bank_seq_if bus2();

  logic          dsel = 1'b0;
  logic          r_valid = 1'b0;
  logic          r_we = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] r_wdata = '0;

  assign bus1.req_valid = r_valid && !dsel;
  assign bus2.req_valid = r_valid && dsel;
  assign bus1.req_we = r_we;     assign bus2.req_we = r_we;
  assign bus1.req_addr = r_addr; assign bus2.req_addr = r_addr;
  assign bus1.req_wdata = r_wdata; assign bus2.req_wdata = r_wdata;

  logic          busy1, s_n1, w_n1, g_n1, r_n1, busy2, s_n2, w_n2, g_n2, r_n2;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] d1, d2, q1, q2;
  logic          verr1, verr2;

  am9150_bank_seq dut1 (
    .sysclk(sysclk), .sys_rst(sys_rst), .req_bus(bus1), .busy(busy1),
    .mem_a(a1), .mem_d(d1), .mem_s_n(s_n1), .mem_w_n(w_n1), .mem_g_n(g_n1),
    .mem_r_n(r_n1), .mem_q(q1)
`ifdef AM9150_SEQ_VERIFY_EN
    , .verify_err(verr1)
`endif
  );

  am9150_bank_seq #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(0)) dut2 (
    .sysclk(sysclk), .sys_rst(sys_rst), .req_bus(bus2), .busy(busy2),
    .mem_a(a2), .mem_d(d2), .mem_s_n(s_n2), .mem_w_n(w_n2), .mem_g_n(g_n2),
    .mem_r_n(r_n2), .mem_q(q2)
`ifdef AM9150_SEQ_VERIFY_EN
    , .verify_err(verr2)
`endif
  );

`ifndef AM9150_SEQ_VERIFY_EN
  assign verr1 = 1'b0;
  assign verr2 = 1'b0;
`endif

  // Behavioural RAM for dut1; dut2 only needs timing, so its Q is zero.
  logic [DW-1:0] ram [RAM_WORDS];
  logic          preload = 1'b1;
  logic [DW-1:0] err_mask;
`ifdef AM9150_SEQ_VERIFY_EN
  assign err_mask = (a1 == 10'h010) ? 4'h1 : 4'h0;
`else
  assign err_mask = 4'h0;
`endif
  assign q1 = (!s_n1 && !g_n1) ? (ram[a1] ^ err_mask) : 4'h0;
  assign q2 = 4'h0;

  always @(posedge sysclk) begin
    if (preload) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= 4'h8 | 4'(i);
    end else if (!s_n1 && !w_n1) begin
      ram[a1] <= d1;
    end
  end

  int overlap = 0;
  always @(negedge sysclk) begin
    if ((!w_n1 && !g_n1) || (!w_n2 && !g_n2)) overlap <= overlap + 1;
  end

  wire          o_ready = dsel ? bus2.req_ready : bus1.req_ready;
  wire          o_rv    = dsel ? bus2.rsp_valid : bus1.rsp_valid;
  wire [DW-1:0] o_rd    = dsel ? bus2.rsp_rdata : bus1.rsp_rdata;
  wire          o_s_n   = dsel ? s_n2 : s_n1;
  wire          o_w_n   = dsel ? w_n2 : w_n1;
  wire          o_g_n   = dsel ? g_n2 : g_n1;
  wire [AW-1:0] o_a     = dsel ? a2 : a1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Count sweep writes on dut1 from reset release until req_ready rises.
  task automatic watch_sweep(output int wr_cnt, output int first_a, output int last_a,
                             output int busy_low, output int cyc);
    logic prev_w;
    prev_w = 1'b1;
    wr_cnt = 0; first_a = -1; last_a = -1; busy_low = 0; cyc = 0;
    while (!bus1.req_ready && cyc < 12000) begin
      if (!w_n1 && prev_w) begin
        if (wr_cnt == 0) first_a = int'(a1);
        last_a = int'(a1);
        wr_cnt++;
      end
      if (!busy1) busy_low++;
      prev_w = w_n1;
      @(negedge sysclk);
      cyc++;
    end
  endtask

  task automatic sweep_checks(input string tag);
    int wc, fa, la, bl, cy, bad;
    watch_sweep(wc, fa, la, bl, cy);
    check({tag, "_done"}, 32'(bus1.req_ready), 32'd1);
    check({tag, "_writes"}, 32'(wc), 32'd1024);
    check({tag, "_first_addr"}, 32'(fa), 32'd0);
    check({tag, "_last_addr"}, 32'(la), 32'd1023);
    check({tag, "_busy_during"}, 32'(bl), 32'd0);
    check({tag, "_busy_after"}, 32'(busy1), 32'd0);
    bad = 0;
    for (int i = 0; i < RAM_WORDS; i++) if (ram[i] != 4'h0) bad++;
    check({tag, "_ram_nonzero"}, 32'(bad), 32'd0);
  endtask

  // One request through the selected DUT; measures strobe shapes.
  task automatic run_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat, output int sn, output int wn, output int gn,
                            output int wfirst, output int a_bad, output logic [DW-1:0] rd,
                            output logic [DW-1:0] rd_after, output int rv_after);
    int n;
    @(negedge sysclk);
    r_we = we; r_addr = a; r_wdata = d; r_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 200) begin @(negedge sysclk); n++; end
    @(negedge sysclk);
    r_valid = 1'b0;
    lat = 0; sn = 0; wn = 0; gn = 0; wfirst = 0; a_bad = 0; rd = '0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (!o_s_n) begin sn++; if (o_a != a) a_bad++; end
      if (!o_w_n) begin wn++; if (wfirst == 0) wfirst = k; end
      if (!o_g_n) gn++;
      if (o_rv) begin lat = k; rd = o_rd; end
      else @(negedge sysclk);
    end
    @(negedge sysclk);
    rd_after = o_rd;
    rv_after = int'(o_rv);
  endtask

  typedef struct {
    logic sel; logic we; logic [AW-1:0] a; logic [DW-1:0] d;
    int lat; int sn; int wn; int gn; int wfirst; logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, sn, wn, gn, wf, ab, rva;
    logic [DW-1:0] rd, rda;
    logic [AW-1:0] qa [3];
    logic [DW-1:0] qd [3];
    logic          qw [3];
    int idx, n_acc, n_rsp, order_bad, n;
    logic acc_now;
    logic [DW-1:0] rd_last;

    vecs[0] = '{1'b0, 1'b1, 10'h3FF, 4'hA, WL1, WS1, 2, WG1, 2, 4'h0};
    vecs[1] = '{1'b0, 1'b0, 10'h3FF, 4'h0, 5,   4,   0, 2,   0, 4'hA};
    vecs[2] = '{1'b0, 1'b1, 10'h000, 4'h5, WL1, WS1, 2, WG1, 2, 4'hA};
    vecs[3] = '{1'b0, 1'b0, 10'h000, 4'h0, 5,   4,   0, 2,   0, 4'h5};
    vecs[4] = '{1'b0, 1'b0, 10'h200, 4'h0, 5,   4,   0, 2,   0, 4'h0};
    vecs[5] = '{1'b0, 1'b1, 10'h155, 4'hC, WL1, WS1, 2, WG1, 2, 4'h0};
    vecs[6] = '{1'b0, 1'b0, 10'h155, 4'h0, 5,   4,   0, 2,   0, 4'hC};
    vecs[7] = '{1'b1, 1'b1, 10'h2AA, 4'h6, WL2, WS2, 1, WG2, 4, 4'h0};

    // Reset state.
    @(posedge sysclk);
    preload = 1'b0;
    #3;
    check("rst_ctrl", 32'({busy1, bus1.req_ready, s_n1, w_n1, g_n1, r_n1, bus1.rsp_valid}),
          32'(7'b1011110));
    check("rst_a_d_rdata", 32'({a1, d1, bus1.rsp_rdata}), 32'd0);
    check("rst_verify_err", 32'(verr1), 32'd0);
    @(negedge sysclk);
    @(negedge sysclk);
    sys_rst = 1'b0;

    sweep_checks("sweep1");
`ifdef AM9150_SEQ_VERIFY_EN
    check("verify_err_set", 32'(verr1), 32'd1);
`endif

    // Table of single accesses.
    for (int i = 0; i < 8; i++) begin
      dsel = vecs[i].sel;
      run_access(vecs[i].we, vecs[i].a, vecs[i].d, lat, sn, wn, gn, wf, ab, rd, rda, rva);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_s_n_low", i), 32'(sn), 32'(vecs[i].sn));
      check($sformatf("v%0d_w_n_low", i), 32'(wn), 32'(vecs[i].wn));
      check($sformatf("v%0d_g_n_low", i), 32'(gn), 32'(vecs[i].gn));
      check($sformatf("v%0d_w_n_start", i), 32'(wf), 32'(vecs[i].wfirst));
      check($sformatf("v%0d_addr_stable", i), 32'(ab), 32'd0);
      check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_rdata_hold", i), 32'(rda), 32'(vecs[i].rd));
      check($sformatf("v%0d_rsp_pulse", i), 32'(rva), 32'd0);
    end
    dsel = 1'b0;

    // Back-to-back: three queued requests with req_valid held.
    qw[0] = 1'b1; qa[0] = 10'h001; qd[0] = 4'h3;
    qw[1] = 1'b1; qa[1] = 10'h002; qd[1] = 4'h7;
    qw[2] = 1'b0; qa[2] = 10'h001; qd[2] = 4'h0;
    idx = 0; n_acc = 0; n_rsp = 0; order_bad = 0; rd_last = '0;
    @(negedge sysclk);
    r_we = qw[0]; r_addr = qa[0]; r_wdata = qd[0]; r_valid = 1'b1;
    for (int c = 0; c < 300 && n_rsp < 3; c++) begin
      if (o_rv) begin
        n_rsp++;
        if (n_rsp != n_acc) order_bad++;
        rd_last = o_rd;
      end
      acc_now = o_ready && r_valid;
      @(negedge sysclk);
      if (acc_now) begin
        n_acc++;
        idx++;
        if (idx < 3) begin r_we = qw[idx]; r_addr = qa[idx]; r_wdata = qd[idx]; end
        else r_valid = 1'b0;
      end
    end
    r_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("b2b_responses", 32'(n_rsp), 32'd3);
    check("b2b_order", 32'(order_bad), 32'd0);
    check("b2b_read_data", 32'(rd_last), 32'h3);
    check("b2b_ram_002", 32'(ram[2]), 32'h7);
    check("w_g_overlap", 32'(overlap), 32'd0);

    // Reset during the write strobe of 0x155 aborts and restarts the sweep.
    @(negedge sysclk);
    r_we = 1'b1; r_addr = 10'h155; r_wdata = 4'h9; r_valid = 1'b1;
    n = 0;
    while (w_n1 && n < 100) begin @(negedge sysclk); n++; end
    check("abort_reached_strobe", 32'(w_n1), 32'd0);
    r_valid = 1'b0;
    sys_rst = 1'b1;
    #1;
    check("abort_strobes_high", 32'({s_n1, w_n1, g_n1}), 32'(3'b111));
    check("abort_busy_ready", 32'({busy1, bus1.req_ready}), 32'(2'b10));
    check("abort_addr_zero", 32'(a1), 32'd0);
    @(negedge sysclk);
    sys_rst = 1'b0;
    sweep_checks("sweep2");
`ifdef AM9150_SEQ_VERIFY_EN
    check("verify_err_sticky", 32'(verr1), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
